// File: rtl/alu_seq_param.sv
// Registered, WIDTH-generic ALU with valid/ready handshakes on both sides.
// Single-cycle ops go straight to DONE. MUL runs a shift-add loop, one bit per cycle.
// Only one operation is in flight at a time.
module alu_seq_param #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    input  logic             carryin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             cout,
    output logic             zero,
    output logic             ovf
);

    localparam int CNTW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_p_hi;
    logic [WIDTH-1:0] r_p_lo;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_y_hi;
    logic             r_cout;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_shl;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;
    logic             w_ovf;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_p_hi_nxt;
    logic [WIDTH-1:0] w_p_lo_nxt;

    // Ready in IDLE, or in DONE when the consumer takes the result this cycle;
    // forced low while reset is held.
    assign in_ready = ~rst & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept = in_valid & in_ready;

    assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carryin};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Extra top bit catches the last bit shifted out; it stays 0 for a zero shift.
    assign w_shl = {1'b0, a} << b[SHW-1:0];

    // Single-cycle datapath: result, carry and signed overflow for the incoming op
    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        case (s)
            OP_ADD: begin
                w_res  = w_add[WIDTH-1:0];
                w_cout = w_add[WIDTH];
                w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) & (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res  = w_sub[WIDTH-1:0];
                w_cout = w_sub[WIDTH];
                w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) & (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_XOR: w_res = a ^ b;
            OP_NOT: w_res = ~a;
            OP_SHL: begin
                w_res  = w_shl[WIDTH-1:0];
                w_cout = w_shl[WIDTH];
            end
            default: ;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the high half,
    // then shift the whole {carry, hi, lo} product right by one.
    assign w_mul_sum  = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_p_hi_nxt = w_mul_sum[WIDTH:1];
    assign w_p_lo_nxt = {w_mul_sum[0], r_p_lo[WIDTH-1:1]};

    // Control FSM plus the result and multiplier registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_p_hi      <= '0;
            r_p_lo      <= '0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_y_hi      <= '0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_accept) begin
            // Accept from IDLE or back-to-back from DONE
            if (s == OP_MUL) begin
                r_state     <= S_BUSY;
                r_cnt       <= '0;
                r_mcand     <= a;
                r_p_hi      <= '0;
                r_p_lo      <= b;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
                r_y         <= w_res;
                r_y_hi      <= '0;
                r_cout      <= w_cout;
                r_zero      <= (w_res == '0);
                r_ovf       <= w_ovf;
            end
        end else if (r_state == S_BUSY) begin
            r_p_hi <= w_p_hi_nxt;
            r_p_lo <= w_p_lo_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CNTW'(WIDTH - 1)) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
                r_y         <= w_p_lo_nxt;
                r_y_hi      <= w_p_hi_nxt;
                r_cout      <= 1'b0;
                r_zero      <= ({w_p_hi_nxt, w_p_lo_nxt} == '0);
                r_ovf       <= 1'b0;
            end
        end else if ((r_state == S_DONE) && out_ready) begin
            // Result taken, nothing new offered
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_hi      = r_y_hi;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised and directed bench for alu_seq_param at WIDTH=8, checked against
// an arithmetic reference model.
module tb_alu_seq_param;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic [2:0]   s;
    logic         carryin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y, y_hi;
    logic         cout, zero, ovf;

    int checks   = 0;
    int failures = 0;

    alu_seq_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .carryin(carryin),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_hi(y_hi), .cout(cout), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, signed range test for overflow
    function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                  input logic [2:0] ms, input logic mc,
                                  output logic [7:0] ey, output logic [7:0] eyh,
                                  output logic ec, output logic ez, output logic eo);
        int unsigned u;
        int r, sa, sb, sh;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ey = 8'h00; eyh = 8'h00; ec = 1'b0; eo = 1'b0;
        case (ms)
            3'd0: begin
                u  = int'(ma) + int'(mb) + int'(mc);
                ey = 8'(u); ec = (u > 255);
                r  = sa + sb + int'(mc); eo = (r > 127) || (r < -128);
            end
            3'd1: begin
                ey = 8'(int'(ma) - int'(mb)); ec = (ma >= mb);
                r  = sa - sb; eo = (r > 127) || (r < -128);
            end
            3'd2: ey = ma & mb;
            3'd3: ey = ma | mb;
            3'd4: ey = ma ^ mb;
            3'd5: ey = ~ma;
            3'd6: begin
                sh = int'(mb % 8);
                ey = 8'(int'(ma) * (1 << sh));
                ec = (sh == 0) ? 1'b0 : 1'((int'(ma) >> (8 - sh)) & 1);
            end
            default: begin
                u   = int'(ma) * int'(mb);
                ey  = 8'(u);
                eyh = 8'(u / 256);
            end
        endcase
        ez = ({eyh, ey} == 16'h0000);
    endfunction

    // Issue one op from idle with out_ready=1 and check latency, outputs and release
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] ts,
                         input logic tc, input string nm);
        logic [7:0] ey, eyh;
        logic ec, ez, eo;
        int lat, elat;
        model(ta, tb, ts, tc, ey, eyh, ec, ez, eo);
        elat = (ts == 3'd7) ? W + 1 : 1;
        out_ready = 1'b1;
        a = ta; b = tb; s = ts; carryin = tc; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL %s ready_before_accept: got %b need 1", nm, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); s = 3'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL %s busy_in_ready: got %b need 0 at lat %0d", nm, in_ready, lat);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != elat) begin
            failures++; $display("FAIL %s latency: got %0d need %0d", nm, lat, elat);
        end
        checks++;
        if ({y_hi, y, cout, zero, ovf} !== {eyh, ey, ec, ez, eo}) begin
            failures++;
            $display("FAIL %s result: got y_hi=%h y=%h c=%b z=%b v=%b need y_hi=%h y=%h c=%b z=%b v=%b",
                     nm, y_hi, y, cout, zero, ovf, eyh, ey, ec, ez, eo);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL %s release: got valid=%b ready=%b need 0/1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; s = '0; carryin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, y_hi, y, cout, zero, ovf} !== '0) begin
            failures++; $display("FAIL reset_state: got rdy=%b vld=%b y_hi=%h y=%h c=%b z=%b v=%b need all 0",
                                 in_ready, out_valid, y_hi, y, cout, zero, ovf);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release: got rdy=%b vld=%b need 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_op(8'hFF, 8'h01, 3'd0, 1'b0, "add_wrap");
        do_op(8'h7F, 8'h00, 3'd0, 1'b1, "add_cin_ovf");
        do_op(8'h80, 8'h01, 3'd1, 1'b0, "sub_ovf");
        do_op(8'h01, 8'h02, 3'd1, 1'b1, "sub_borrow");
        do_op(8'h81, 8'h03, 3'd6, 1'b0, "shl3");
        do_op(8'h81, 8'h01, 3'd6, 1'b0, "shl1");
        do_op(8'hA5, 8'h00, 3'd6, 1'b0, "shl0");
        do_op(8'h3C, 8'h0F, 3'd5, 1'b0, "not");
        do_op(8'hFF, 8'hFF, 3'd7, 1'b0, "mul_ff");
        do_op(8'h00, 8'h9A, 3'd7, 1'b0, "mul_zero");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            do_op(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), "random");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        a = 8'h03; b = 8'h04; s = 3'd0; carryin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        // Next op waits at the input while the ADD result is held
        a = 8'hF0; b = 8'h0F; s = 3'd4;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || y !== 8'h07 || in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold: got vld=%b y=%h rdy=%b need 1/07/0 cycle %0d",
                                     out_valid, y, in_ready, i);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready: got %b need 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || y !== 8'hFF) begin
            failures++; $display("FAIL bp_next_result: got vld=%b y=%h need 1/FF", out_valid, y);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL bp_once: got vld=%b need 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] ta, tb;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ta = 8'($urandom); tb = 8'($urandom);
            exp_q.push_back(ta ^ tb);
            a = ta; b = tb; s = 3'd4; in_valid = 1'b1;
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b1 || y !== exp_q[i-1]) begin
                    failures++; $display("FAIL b2b_result%0d: got vld=%b rdy=%b y=%h need 1/1/%h",
                                         i - 1, out_valid, in_ready, y, exp_q[i-1]);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || y !== exp_q[3]) begin
            failures++; $display("FAIL b2b_result3: got vld=%b y=%h need 1/%h", out_valid, y, exp_q[3]);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_drain: got vld=%b need 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        do_op(8'h55, 8'h0F, 3'd4, 1'b0, "pre_mul_xor");
        a = 8'hFF; b = 8'hFF; s = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid, y_hi, y, cout, zero, ovf} !== '0) begin
            failures++; $display("FAIL mid_mul_reset: got rdy=%b vld=%b y_hi=%h y=%h c=%b z=%b v=%b need all 0",
                                 in_ready, out_valid, y_hi, y, cout, zero, ovf);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        do_op(8'h01, 8'h01, 3'd0, 1'b0, "post_reset_add");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
